// File: rtl/front_panel_pkg.sv
// Shared switch encodings and event types for the
// front panel switch mapper.
package front_panel_pkg;

  typedef logic [1:0] sw_state_t;

  localparam sw_state_t SW_OFF     = 2'b00;
  localparam sw_state_t SW_UP      = 2'b01;
  localparam sw_state_t SW_DOWN    = 2'b10;
  localparam sw_state_t SW_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    EV_NONE = 2'b00,
    EV_UP   = 2'b01,
    EV_DOWN = 2'b10
  } ev_code_t;

endpackage

// File: rtl/front_panel_switch_mapper_if.sv
// Momentary-switch event handshake between the
// panel mapper and the CPU control logic.
interface front_panel_switch_mapper_if #(
  parameter int IDX_W = 5
) ();
  import front_panel_pkg::*;

  logic             event_valid;
  logic             event_ready;
  logic [IDX_W-1:0] event_index;
  ev_code_t         event_code;
  logic             event_overrun;

  modport master (
    output event_valid,
    output event_index,
    output event_code,
    output event_overrun,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_index,
    input  event_code,
    input  event_overrun,
    output event_ready
  );

endinterface

// File: rtl/front_panel_debounce.sv
// One panel switch: 2-flop sync, stability counter,
// committed state and a commit strobe for the next edge.
module front_panel_debounce
  import front_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  sw_state_t raw,
  output sw_state_t stable,
  output sw_state_t sync_val,
  output logic      commit
);

  localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

  sw_state_t   s1;
  sw_state_t   s2;
  sw_state_t   prev;
  logic [15:0] cnt;
  logic [15:0] eff;
  logic        hold;

  assign sync_val = s2;

  // a new candidate value counts as if the counter were at 0
  always_comb begin
    hold   = (s2 == stable) || (s2 == SW_ILLEGAL);
    eff    = (s2 != prev) ? '0 : cnt;
    commit = !hold && (eff == LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= SW_OFF;
      s2     <= SW_OFF;
      prev   <= SW_OFF;
      cnt    <= '0;
      stable <= SW_OFF;
    end else begin
      s1   <= raw;
      s2   <= s1;
      prev <= s2;
      if (hold) begin
        cnt <= '0;
      end else if (commit) begin
        cnt    <= '0;
        stable <= s2;
      end else begin
        cnt <= eff + 16'd1;
      end
    end
  end

endmodule

// File: rtl/front_panel_switch_mapper.sv
// Panel switch debounce, toggle LED drive and queued
// momentary press events with valid/ready handshake.
module front_panel_switch_mapper
  import front_panel_pkg::*;
#(
  parameter int SWITCHES_TOTAL_NUMBER = 25,
  parameter int LEDS_TOTAL_NUMBER     = 36,
  parameter int DEBOUNCE_CYCLES       = 16,
  parameter logic [SWITCHES_TOTAL_NUMBER-1:0] TOGGLE_MASK = 25'h00FFFF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  sw_state_t [SWITCHES_TOTAL_NUMBER-1:0] switches_status,
  input  logic [LEDS_TOTAL_NUMBER-1:0]        leds_ext,
  output logic [LEDS_TOTAL_NUMBER-1:0]        leds_status,
  output sw_state_t [SWITCHES_TOTAL_NUMBER-1:0] sw_stable,
  front_panel_switch_mapper_if.master         ev
);

  localparam int SW = SWITCHES_TOTAL_NUMBER;
  localparam int LN = LEDS_TOTAL_NUMBER;
  localparam int IDX_W = (SW > 1) ? $clog2(SW) : 1;
  localparam logic [LN-1:0] TMASK = LN'(TOGGLE_MASK);

  sw_state_t [SW-1:0] sync_val;
  logic [SW-1:0]      commit;
  logic [SW-1:0]      pend;
  ev_code_t           pend_code [SW];
  logic [SW-1:0]      set;
  logic [SW-1:0]      clr;
  logic [IDX_W-1:0]   sel;
  logic               any;
  logic               load;
  logic [LN-1:0]      up_vec;

  logic               valid_q;
  logic [IDX_W-1:0]   index_q;
  ev_code_t           code_q;
  logic               overrun_q;

  for (genvar g = 0; g < SW; g++) begin : g_sw
    front_panel_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .raw     (switches_status[g]),
      .stable  (sw_stable[g]),
      .sync_val(sync_val[g]),
      .commit  (commit[g])
    );
  end

  // a committing momentary switch leaving centre is a press
  always_comb begin
    set    = '0;
    up_vec = '0;
    for (int i = 0; i < SW; i++) begin
      set[i] = !TOGGLE_MASK[i] && commit[i] &&
               (sw_stable[i] == SW_OFF);
      up_vec[i] = (sw_stable[i] == SW_UP);
    end
  end

  always_comb begin
    sel = '0;
    any = |pend;
    for (int i = SW - 1; i >= 0; i--) begin
      if (pend[i]) sel = IDX_W'(i);
    end
    load = !valid_q || ev.event_ready;
    clr  = '0;
    if (load && any) clr[sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend      <= '0;
      valid_q   <= 1'b0;
      index_q   <= '0;
      code_q    <= EV_NONE;
      overrun_q <= 1'b0;
      for (int i = 0; i < SW; i++) pend_code[i] <= EV_NONE;
    end else begin
      pend      <= (pend & ~clr) | set;
      overrun_q <= |(set & pend & ~clr);
      for (int i = 0; i < SW; i++) begin
        if (set[i]) pend_code[i] <= ev_code_t'(sync_val[i]);
      end
      if (load) begin
        valid_q <= any;
        if (any) begin
          index_q <= sel;
          code_q  <= pend_code[sel];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) leds_status <= '0;
    else       leds_status <= leds_ext | (up_vec & TMASK);
  end

  assign ev.event_valid   = valid_q;
  assign ev.event_index   = index_q;
  assign ev.event_code    = code_q;
  assign ev.event_overrun = overrun_q;

endmodule

// File: tb/tb_front_panel_switch_mapper.sv
// Directed bench: toggle/LED vector table plus
// event queue, overrun and reset sequences.
module tb_front_panel_switch_mapper;
  import front_panel_pkg::*;

  localparam int SW = 25;
  localparam int LN = 36;

  logic               clk;
  logic               reset;
  sw_state_t [SW-1:0] raw;
  logic [LN-1:0]      leds_ext;
  logic [LN-1:0]      leds_status;
  sw_state_t [SW-1:0] sw_stable;

  front_panel_switch_mapper_if #(.IDX_W(5)) ev ();

  front_panel_switch_mapper #(
    .SWITCHES_TOTAL_NUMBER(SW),
    .LEDS_TOTAL_NUMBER    (LN),
    .DEBOUNCE_CYCLES      (4),
    .TOGGLE_MASK          (25'h00FFFF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .switches_status(raw),
    .leds_ext       (leds_ext),
    .leds_status    (leds_status),
    .sw_stable      (sw_stable),
    .ev             (ev)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    sw_state_t     r;
    logic [LN-1:0] ext;
    sw_state_t     st;
    logic [LN-1:0] leds;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  int   ov_cnt = 0;

  function automatic void add(sw_state_t r, logic [LN-1:0] ext,
                              sw_state_t st, logic [LN-1:0] leds);
    vec_t v;
    v.r = r; v.ext = ext; v.st = st; v.leds = leds;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    repeat (n) begin
      step(1);
      if (ev.event_overrun) ov_cnt++;
    end
  endtask

  initial begin
    reset          = 1'b1;
    raw            = '0;
    leds_ext       = '0;
    ev.event_ready = 1'b0;

    // toggle switch 3 sequence, one record per clock
    repeat (5) add(SW_UP, '0, SW_OFF, '0);
    add(SW_UP, '0, SW_UP, '0);
    add(SW_UP, '0, SW_UP, 36'h8);
    repeat (5) add(SW_OFF, '0, SW_UP, 36'h8);
    add(SW_OFF, '0, SW_OFF, 36'h8);
    add(SW_OFF, '0, SW_OFF, '0);
    repeat (3) add(SW_UP, '0, SW_OFF, '0);
    repeat (6) add(SW_OFF, '0, SW_OFF, '0);
    repeat (10) add(SW_ILLEGAL, '0, SW_OFF, '0);
    repeat (4) add(SW_OFF, '0, SW_OFF, '0);
    add(SW_OFF, 36'h800000001, SW_OFF, 36'h800000001);
    add(SW_OFF, 36'h8, SW_OFF, 36'h8);
    add(SW_OFF, '0, SW_OFF, '0);

    step(2);
    chk("rst_valid", ev.event_valid, 0);
    chk("rst_leds", leds_status, 0);
    chk("rst_stable", sw_stable, 0);
    chk("rst_overrun", ev.event_overrun, 0);
    reset = 1'b0;

    foreach (vecs[k]) begin
      raw[3]   = vecs[k].r;
      leds_ext = vecs[k].ext;
      run(1);
      chk($sformatf("tbl%0d_st", k), sw_stable[3], vecs[k].st);
      chk($sformatf("tbl%0d_led", k), leds_status, vecs[k].leds);
    end
    chk("toggle_no_event", ev.event_valid, 0);

    // two momentary presses committing together
    raw[17] = SW_DOWN;
    raw[20] = SW_UP;
    step(6);
    chk("a_not_yet", ev.event_valid, 0);
    step(1);
    chk("a_valid", ev.event_valid, 1);
    chk("a_idx17", ev.event_index, 17);
    chk("a_code17", ev.event_code, EV_DOWN);
    step(3);
    chk("a_hold_idx", ev.event_index, 17);
    chk("a_hold_valid", ev.event_valid, 1);
    ev.event_ready = 1'b1;
    step(1);
    ev.event_ready = 1'b0;
    chk("a_idx20", ev.event_index, 20);
    chk("a_code20", ev.event_code, EV_UP);
    chk("a_valid20", ev.event_valid, 1);
    step(1);
    chk("a_hold20", ev.event_index, 20);
    ev.event_ready = 1'b1;
    step(1);
    ev.event_ready = 1'b0;
    chk("a_empty", ev.event_valid, 0);
    raw[17] = SW_OFF;
    raw[20] = SW_OFF;
    run(8);
    chk("a_release_quiet", ev.event_valid, 0);

    // overwrite of a pending press while output is busy
    ov_cnt  = 0;
    raw[17] = SW_UP;
    run(7);
    chk("b_busy17", ev.event_index, 17);
    raw[20] = SW_UP;
    run(7);
    raw[20] = SW_OFF;
    run(7);
    raw[20] = SW_DOWN;
    run(7);
    chk("b_overrun_once", ov_cnt, 1);
    chk("b_still17", ev.event_index, 17);
    ev.event_ready = 1'b1;
    step(1);
    ev.event_ready = 1'b0;
    chk("b_idx20", ev.event_index, 20);
    chk("b_code_down", ev.event_code, EV_DOWN);
    ev.event_ready = 1'b1;
    step(1);
    ev.event_ready = 1'b0;
    chk("b_empty", ev.event_valid, 0);
    raw[17] = SW_OFF;
    raw[20] = SW_OFF;
    run(8);
    chk("b_ov_total", ov_cnt, 1);

    // back-to-back drain with ready held
    ov_cnt         = 0;
    ev.event_ready = 1'b1;
    raw[16] = SW_UP;
    raw[18] = SW_UP;
    raw[19] = SW_UP;
    run(6);
    chk("c_not_yet", ev.event_valid, 0);
    run(1);
    chk("c_idx16", ev.event_index, 16);
    chk("c_v16", ev.event_valid, 1);
    run(1);
    chk("c_idx18", ev.event_index, 18);
    run(1);
    chk("c_idx19", ev.event_index, 19);
    chk("c_code19", ev.event_code, EV_UP);
    run(1);
    chk("c_empty", ev.event_valid, 0);
    chk("c_no_overrun", ov_cnt, 0);
    ev.event_ready = 1'b0;
    raw[16] = SW_OFF;
    raw[18] = SW_OFF;
    raw[19] = SW_OFF;
    step(8);

    // asynchronous reset mid-debounce with an event held
    raw[3]  = SW_UP;
    raw[22] = SW_UP;
    step(7);
    chk("d_pre_valid", ev.event_valid, 1);
    chk("d_pre_led", leds_status[3], 1);
    raw[21] = SW_UP;
    step(3);
    #1;
    reset = 1'b1;
    #1;
    chk("d_rst_valid", ev.event_valid, 0);
    chk("d_rst_idx", ev.event_index, 0);
    chk("d_rst_code", ev.event_code, 0);
    chk("d_rst_leds", leds_status, 0);
    chk("d_rst_stable", sw_stable, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(5);
    chk("d_sw21_wait", sw_stable[21], SW_OFF);
    step(1);
    chk("d_sw21_done", sw_stable[21], SW_UP);
    chk("d_sw3_done", sw_stable[3], SW_UP);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/front_panel_switch_mapper.md
Name: front_panel_switch_mapper

Overview:
- Parametrised front-panel interface between the panel switch inputs and the machine core.
- Per switch: synchronises raw 2-bit status, debounces it, and classifies it as a toggle or momentary switch.
- Toggle switches drive their LEDs. Momentary switches produce queued press events with a valid/ready handshake.
- Sits between the panel I/O decode and the CPU control logic (examine, deposit, run, stop, reset actions).

Parameters:
- SWITCHES_TOTAL_NUMBER, 25, number of panel switches.
- LEDS_TOTAL_NUMBER, 36, number of panel LEDs; must be >= SWITCHES_TOTAL_NUMBER.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to commit a new switch state; range 2..65535.
- TOGGLE_MASK, 25'h00FFFF, bit i=1 means switch i is a toggle; 0 means momentary.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- switches_status  input  [1:0] x SWITCHES_TOTAL_NUMBER  raw switch state: 00 centre/off, 01 up/on, 10 down, 11 illegal
- leds_ext  input  LEDS_TOTAL_NUMBER  core-driven LED values
- leds_status  output  LEDS_TOTAL_NUMBER  registered LED outputs
- sw_stable  output  [1:0] x SWITCHES_TOTAL_NUMBER  debounced switch states
- event_valid  output  1  momentary event available
- event_ready  input  1  consumer accepts event
- event_index  output  $clog2(SWITCHES_TOTAL_NUMBER)  switch number of the event
- event_code  output  2  01 up-press, 10 down-press
- event_overrun  output  1  one-cycle pulse when a pending event is overwritten

Behaviour:
- Reset (asynchronous, active-high) clears all sync flops, counters, sw_stable (00), pending bits, leds_status, event_valid, event_index, event_code and event_overrun to 0.
- Sync: each switch passes through 2 flops. Result is sw_sync.
- Debounce, per switch:
  - 16-bit counter.
  - If sw_sync == sw_stable, or sw_sync == 11: counter cleared.
  - Otherwise counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sw_sync still different, sw_stable <= sw_sync on that edge and the counter clears.
  - A change of sw_sync mid-count to another non-stable legal value restarts the count at 0.
  - Latency from raw change to sw_stable = 2 + DEBOUNCE_CYCLES cycles.
- Commit pulse: one cycle, asserted on the edge where sw_stable changes.
- LEDs (registered, one cycle after sw_stable):
  - For i < SWITCHES_TOTAL_NUMBER with TOGGLE_MASK[i]=1: leds_status[i] = (sw_stable[i]==01) | leds_ext[i].
  - For all other indices: leds_status[i] = leds_ext[i].
- Events (momentary switches only):
  - A commit from 00 to 01 or from 00 to 10 sets pend[i] and pend_code[i].
  - A commit back to 00 generates nothing.
  - If pend[i] is already set when a new press commits: pend_code is overwritten and event_overrun pulses for 1 cycle.
- Output register:
  - When event_valid=0, or event_valid & event_ready, load the lowest-index pending switch the next cycle. event_valid=1 iff a pending bit existed; that pend bit is cleared on the load edge.
  - event_index and event_code are held stable while event_valid & !event_ready.
- Simultaneous set and clear of the same pend bit: set wins; the new press stays pending.
- Back-to-back throughput: 1 event per cycle when event_ready is held high.
- Latency from press commit to event_valid: 1 cycle if the output is idle.
- Toggle switches never set pend bits.

Decomposition:
- Package front_panel_pkg holds:
  - switch encoding constants SW_OFF=00, SW_UP=01, SW_DOWN=10, SW_ILLEGAL=11;
  - typedef sw_state_t logic[1:0];
  - event code typedef.
- Sub-module front_panel_debounce (one switch: 2-flop sync, counter, sw_stable, commit pulse), instantiated SWITCHES_TOTAL_NUMBER times in a generate loop.
- Top level holds the pending array, priority select, output register and LED register.

Test Plan:
- DEBOUNCE_CYCLES=4; switch 3 (toggle) raw 00->01 held → sw_stable[3]=01 at cycle 6, leds_status[3]=1 at cycle 7; leds_ext=0.
- Switch 3 raw glitch 00->01 for 3 cycles then back to 00 → sw_stable stays 00, no LED change; raw 11 for 10 cycles → no change.
- Momentary switches 20 and 17 committed on the same cycle with event_ready=0 → event_valid, index=17, code per press, held; assert ready 1 cycle → next cycle index=20; then event_valid=0.
- Switch 20 up-press, then down-press committed before service → event_overrun pulses once; served event has code=10.
- event_ready held 1, presses on switches 16,18,19 committed together → events 16,18,19 on 3 consecutive cycles.
- Reset asserted mid-debounce and while event_valid=1 → all outputs 0 immediately (asynchronous); after release, raw held 01 requires a full 2+4 cycles again.
